// File: rtl/sdram_client.sv
// rtl/sdram_client.sv - single-client request initiator and return-stream filter for the SDRAM controller
module sdram_client #(
  parameter int AN    = 24,
  parameter int DN    = 16,
  parameter int IN    = 2,
  parameter int ID    = 0,
  parameter int BURST = 8,
  parameter int TMO   = 255
) (
  input  logic          clkSYS,
  input  logic          n_reset,
  input  logic [AN-1:0] cl_addr,
  input  logic [DN-1:0] cl_wdata,
  input  logic          cl_wr,
  input  logic          cl_req,
  output logic          cl_ack,
  output logic [DN-1:0] cl_rdata,
  output logic          cl_rvalid,
  output logic          cl_rlast,
  output logic          cl_busy,
  output logic          cl_err,
  output logic [AN-1:0] req_addr,
  output logic [DN-1:0] req_data,
  output logic [IN-1:0] req_id,
  output logic          req,
  output logic          req_wr,
  input  logic          req_ack,
  input  logic [DN-1:0] mem_data,
  input  logic [IN-1:0] mem_id,
  input  logic          mem_valid
);

  // Beat counter needs at least one bit even for single-word bursts.
  localparam int BW = (BURST > 1) ? $clog2(BURST) : 1;
  localparam int TW = $clog2(TMO + 1);
  // Reads fetch whole bursts, so the low address bits are cleared.
  localparam logic [AN-1:0] ALIGN_MASK = ~(AN'(BURST - 1));

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_RDATA
  } state_t;

  state_t        state_q, state_d;
  logic          req_q, req_d;
  logic          req_wr_q, req_wr_d;
  logic [AN-1:0] req_addr_q, req_addr_d;
  logic [DN-1:0] req_data_q, req_data_d;
  logic          cl_ack_q, cl_ack_d;
  logic          cl_rvalid_q, cl_rvalid_d;
  logic          cl_rlast_q, cl_rlast_d;
  logic [DN-1:0] cl_rdata_q, cl_rdata_d;
  logic          cl_err_q, cl_err_d;
  logic          cl_busy_q, cl_busy_d;
  logic [BW-1:0] beat_q, beat_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          own_beat;

  assign own_beat = mem_valid && (mem_id == IN'(ID));

  // Next-state and registered-output decode for the three-state command FSM.
  always_comb begin
    state_d     = state_q;
    req_d       = req_q;
    req_wr_d    = req_wr_q;
    req_addr_d  = req_addr_q;
    req_data_d  = req_data_q;
    cl_ack_d    = 1'b0;
    cl_rvalid_d = 1'b0;
    cl_rlast_d  = 1'b0;
    cl_rdata_d  = cl_rdata_q;
    cl_err_d    = 1'b0;
    beat_d      = beat_q;
    tmo_d       = tmo_q;

    case (state_q)
      S_IDLE: begin
        // Our ID returning data with no read outstanding is a stray.
        if (own_beat) begin
          cl_err_d = 1'b1;
        end
        if (cl_req) begin
          state_d    = S_REQ;
          req_d      = 1'b1;
          req_wr_d   = cl_wr;
          req_addr_d = cl_wr ? cl_addr : (cl_addr & ALIGN_MASK);
          req_data_d = cl_wdata;
          cl_ack_d   = 1'b1;
        end
      end

      S_REQ: begin
        if (own_beat) begin
          cl_err_d = 1'b1;
        end
        // Request fields are frozen until the controller takes them.
        if (req_ack) begin
          req_d = 1'b0;
          if (req_wr_q) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_RDATA;
            beat_d  = '0;
            tmo_d   = '0;
          end
        end
      end

      S_RDATA: begin
        if (own_beat) begin
          cl_rvalid_d = 1'b1;
          cl_rdata_d  = mem_data;
          tmo_d       = '0;
          beat_d      = beat_q + BW'(1);
          if (beat_q == BW'(BURST - 1)) begin
            cl_rlast_d = 1'b1;
            beat_d     = '0;
            state_d    = S_IDLE;
          end
        end else begin
          // Silence between own beats; give up once the gap hits TMO.
          tmo_d = tmo_q + TW'(1);
          if (tmo_d == TW'(TMO)) begin
            cl_err_d = 1'b1;
            state_d  = S_IDLE;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    cl_busy_d = (state_d != S_IDLE);
  end

  // State and output registers; reset abandons any request in flight.
  always_ff @(posedge clkSYS or negedge n_reset) begin
    if (!n_reset) begin
      state_q     <= S_IDLE;
      req_q       <= 1'b0;
      req_wr_q    <= 1'b0;
      req_addr_q  <= '0;
      req_data_q  <= '0;
      cl_ack_q    <= 1'b0;
      cl_rvalid_q <= 1'b0;
      cl_rlast_q  <= 1'b0;
      cl_rdata_q  <= '0;
      cl_err_q    <= 1'b0;
      cl_busy_q   <= 1'b0;
      beat_q      <= '0;
      tmo_q       <= '0;
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      req_wr_q    <= req_wr_d;
      req_addr_q  <= req_addr_d;
      req_data_q  <= req_data_d;
      cl_ack_q    <= cl_ack_d;
      cl_rvalid_q <= cl_rvalid_d;
      cl_rlast_q  <= cl_rlast_d;
      cl_rdata_q  <= cl_rdata_d;
      cl_err_q    <= cl_err_d;
      cl_busy_q   <= cl_busy_d;
      beat_q      <= beat_d;
      tmo_q       <= tmo_d;
    end
  end

  assign cl_ack    = cl_ack_q;
  assign cl_rdata  = cl_rdata_q;
  assign cl_rvalid = cl_rvalid_q;
  assign cl_rlast  = cl_rlast_q;
  assign cl_busy   = cl_busy_q;
  assign cl_err    = cl_err_q;
  assign req_addr  = req_addr_q;
  assign req_data  = req_data_q;
  assign req_id    = IN'(ID);
  assign req       = req_q;
  assign req_wr    = req_wr_q;

endmodule

// File: tb/tb_sdram_client.sv
// tb/tb_sdram_client.sv - directed and randomized checks of sdram_client against a cycle-count model
module tb_sdram_client;

  localparam int AN    = 24;
  localparam int DN    = 16;
  localparam int IN    = 2;
  localparam int ID    = 1;
  localparam int BURST = 8;
  localparam int TMO   = 16;
  localparam logic [IN-1:0] OWN   = IN'(ID);
  localparam logic [IN-1:0] OTHER = IN'(ID + 1);

  logic          clkSYS = 1'b0;
  logic          n_reset = 1'b0;
  logic [AN-1:0] cl_addr = '0;
  logic [DN-1:0] cl_wdata = '0;
  logic          cl_wr = 1'b0;
  logic          cl_req = 1'b0;
  logic          cl_ack;
  logic [DN-1:0] cl_rdata;
  logic          cl_rvalid;
  logic          cl_rlast;
  logic          cl_busy;
  logic          cl_err;
  logic [AN-1:0] req_addr;
  logic [DN-1:0] req_data;
  logic [IN-1:0] req_id;
  logic          req;
  logic          req_wr;
  logic          req_ack = 1'b0;
  logic [DN-1:0] mem_data = '0;
  logic [IN-1:0] mem_id = '0;
  logic          mem_valid = 1'b0;

  int checks = 0;
  int failures = 0;

  sdram_client #(
    .AN(AN), .DN(DN), .IN(IN), .ID(ID), .BURST(BURST), .TMO(TMO)
  ) dut (
    .clkSYS   (clkSYS),
    .n_reset  (n_reset),
    .cl_addr  (cl_addr),
    .cl_wdata (cl_wdata),
    .cl_wr    (cl_wr),
    .cl_req   (cl_req),
    .cl_ack   (cl_ack),
    .cl_rdata (cl_rdata),
    .cl_rvalid(cl_rvalid),
    .cl_rlast (cl_rlast),
    .cl_busy  (cl_busy),
    .cl_err   (cl_err),
    .req_addr (req_addr),
    .req_data (req_data),
    .req_id   (req_id),
    .req      (req),
    .req_wr   (req_wr),
    .req_ack  (req_ack),
    .mem_data (mem_data),
    .mem_id   (mem_id),
    .mem_valid(mem_valid)
  );

  always #5 clkSYS = ~clkSYS;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clkSYS);
    #1;
  endtask

  task automatic do_write(input logic [AN-1:0] addr, input logic [DN-1:0] data, input int ack_delay);
    cl_addr  = addr;
    cl_wdata = data;
    cl_wr    = 1'b1;
    cl_req   = 1'b1;
    step();
    chk("wr_ack", cl_ack, 1);
    chk("wr_req", req, 1);
    chk("wr_addr", req_addr, addr);
    chk("wr_data", req_data, data);
    chk("wr_we", req_wr, 1);
    chk("wr_id", req_id, OWN);
    chk("wr_busy", cl_busy, 1);
    cl_req   = 1'b0;
    cl_addr  = AN'($urandom);
    cl_wdata = DN'($urandom);
    for (int i = 0; i < ack_delay; i++) begin
      step();
      chk("wr_req_hold", req, 1);
      chk("wr_addr_hold", req_addr, addr);
      chk("wr_data_hold", req_data, data);
      chk("wr_ack_once", cl_ack, 0);
    end
    req_ack = 1'b1;
    step();
    req_ack = 1'b0;
    chk("wr_req_drop", req, 0);
    chk("wr_busy_after", cl_busy, 0);
  endtask

  // Model: a read is finished after BURST own beats, or after TMO
  // consecutive cycles with no own beat. abort_after>0 stops driving
  // after that many beats with the read still outstanding.
  task automatic do_read(input logic [AN-1:0] addr, input int nsend, input bit interleave,
                         input bit seq_data, input logic [DN-1:0] base, input int ack_delay,
                         input int abort_after);
    logic [AN-1:0] exp_addr;
    logic [DN-1:0] d;
    int got, idle, cyc, rv_seen;
    bit own, foreign, done, stop, timed_out, exp_last, exp_err;
    exp_addr = AN'((addr / BURST) * BURST);
    cl_addr  = addr;
    cl_wr    = 1'b0;
    cl_req   = 1'b1;
    step();
    chk("rd_ack", cl_ack, 1);
    chk("rd_req", req, 1);
    chk("rd_addr", req_addr, exp_addr);
    chk("rd_we", req_wr, 0);
    chk("rd_busy", cl_busy, 1);
    // cl_req stays high while busy; it must not be acknowledged again.
    cl_addr = AN'($urandom);
    for (int i = 0; i < ack_delay; i++) begin
      step();
      chk("rd_req_hold", req, 1);
      chk("rd_addr_hold", req_addr, exp_addr);
      chk("rd_ack_busy", cl_ack, 0);
    end
    req_ack = 1'b1;
    step();
    req_ack = 1'b0;
    cl_req  = 1'b0;
    chk("rd_req_drop", req, 0);
    chk("rd_ack_busy", cl_ack, 0);
    chk("rd_busy_wait", cl_busy, 1);
    got = 0; idle = 0; cyc = 0; rv_seen = 0;
    done = 0; stop = 0; timed_out = 0;
    while (!done && !stop && cyc < 400) begin
      own = 0;
      foreign = 0;
      if (got < nsend && (idle >= TMO - 4 || $urandom_range(0, 2) != 0)) own = 1;
      else if (interleave && $urandom_range(0, 1) == 1) foreign = 1;
      d = seq_data ? DN'(base + DN'(got)) : DN'($urandom);
      mem_valid = own | foreign;
      mem_id    = own ? OWN : (foreign ? OTHER : IN'($urandom));
      mem_data  = own ? d : DN'($urandom);
      step();
      exp_last = 0;
      exp_err  = 0;
      if (own) begin
        got++;
        idle = 0;
        exp_last = (got == BURST);
        done = exp_last;
        if (abort_after > 0 && got == abort_after) stop = 1;
      end else begin
        idle++;
        if (idle == TMO) begin
          exp_err = 1;
          done = 1;
          timed_out = 1;
        end
      end
      rv_seen += int'(cl_rvalid);
      chk("rd_rvalid", cl_rvalid, own);
      if (own) chk("rd_rdata", cl_rdata, d);
      chk("rd_rlast", cl_rlast, exp_last);
      chk("rd_err", cl_err, exp_err);
      chk("rd_busy", cl_busy, !done);
      cyc++;
    end
    mem_valid = 1'b0;
    if (!done && !stop) chk("rd_cycle_bound", 0, 1);
    chk("rd_beat_count", rv_seen, (timed_out || stop) ? got : BURST);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req"}, req, 0);
    chk({tag, "_req_wr"}, req_wr, 0);
    chk({tag, "_req_addr"}, req_addr, 0);
    chk({tag, "_req_data"}, req_data, 0);
    chk({tag, "_ack"}, cl_ack, 0);
    chk({tag, "_rvalid"}, cl_rvalid, 0);
    chk({tag, "_rlast"}, cl_rlast, 0);
    chk({tag, "_rdata"}, cl_rdata, 0);
    chk({tag, "_err"}, cl_err, 0);
    chk({tag, "_busy"}, cl_busy, 0);
  endtask

  initial begin
    // Power-on reset values.
    #12;
    chk_reset_outputs("rst");
    chk("rst_id", req_id, OWN);
    @(negedge clkSYS);
    n_reset = 1'b1;
    step();

    // Directed write, then random writes.
    do_write(24'h000123, 16'hBEEF, 3);
    for (int i = 0; i < 3; i++) begin
      do_write(AN'($urandom), DN'($urandom), int'($urandom_range(0, 3)));
    end

    // Directed read with sequential data, then interleaved and random reads.
    do_read(24'h00004D, BURST, 0, 1, 16'h1000, 0, 0);
    do_read(AN'($urandom), BURST, 1, 0, '0, int'($urandom_range(0, 3)), 0);
    do_read(AN'($urandom), BURST, 1, 1, DN'($urandom), 1, 0);

    // Foreign-ID beat while idle: silent.
    mem_valid = 1'b1; mem_id = OTHER; mem_data = DN'($urandom);
    step();
    mem_valid = 1'b0;
    chk("idle_foreign_err", cl_err, 0);
    chk("idle_foreign_rv", cl_rvalid, 0);

    // Timeout after three beats, then a late own beat is a stray.
    do_read(AN'($urandom), 3, 0, 1, 16'h2000, 0, 0);
    mem_valid = 1'b1; mem_id = OWN; mem_data = DN'($urandom);
    step();
    mem_valid = 1'b0;
    chk("stray_err", cl_err, 1);
    chk("stray_rv", cl_rvalid, 0);
    chk("stray_busy", cl_busy, 0);
    step();
    chk("stray_err_pulse", cl_err, 0);

    // Reset in the middle of a read, then a clean read.
    do_read(AN'($urandom), BURST, 0, 1, 16'h3000, 0, 2);
    #2 n_reset = 1'b0;
    #1;
    chk_reset_outputs("mid_rst");
    @(negedge clkSYS);
    n_reset = 1'b1;
    step();
    do_read(AN'($urandom), BURST, 1, 0, '0, 2, 0);

    // Reset while the request is still on the bus: req drops at once.
    cl_addr = AN'($urandom); cl_wr = 1'b0; cl_req = 1'b1;
    step();
    cl_req = 1'b0;
    chk("req_rst_pre", req, 1);
    #2 n_reset = 1'b0;
    #1;
    chk("req_rst_req", req, 0);
    chk("req_rst_busy", cl_busy, 0);
    @(negedge clkSYS);
    n_reset = 1'b1;
    step();
    do_read(AN'($urandom), BURST, 0, 0, '0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
